// File: rtl/mac_pkg.sv
// Shared constants and types for the MAC operand feeder and its operand buffers.
package mac_pkg;

   localparam int DATA_W = 10;
   localparam int DEPTH  = 16;
   localparam int ADDR_W = 4;
   localparam int LEN_W  = ADDR_W + 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      FIN    = 2'd2
   } feeder_state_t;

   typedef struct packed {
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
      logic              first;
      logic              last;
   } pair_t;

   // Requested pair counts above the buffer depth stream the whole buffer once.
   function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] req_len);
      logic [LEN_W-1:0] res;
      if (req_len > LEN_W'(DEPTH)) begin
         res = LEN_W'(DEPTH);
      end else begin
         res = req_len;
      end
      return res;
   endfunction

endpackage

// File: rtl/operand_buf.sv
// Single-write, single-read operand RAM with a registered read port; contents are never reset.
module operand_buf
   import mac_pkg::*;
(
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem_r [DEPTH];
   logic [DATA_W-1:0] rd_data_r;

   // Storage write port.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_r[wr_addr] <= wr_data;
      end
   end

   // Registered read port; the word holds until the next enabled read.
   always_ff @(posedge clk) begin
      if (rd_en) begin
         rd_data_r <= mem_r[rd_addr];
      end
   end

   assign rd_data = rd_data_r;

endmodule

// File: rtl/mac_operand_feeder.sv
// Streams matched (A[i], B[i]) pairs to the MAC datapath with valid/ready, first/last tags and a done pulse.
module mac_operand_feeder
   import mac_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic              wr_sel,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              start,
   input  logic [ADDR_W:0]   len,
   output logic              busy,
   output logic              done,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_a,
   output logic [DATA_W-1:0] out_b,
   output logic              out_first,
   output logic              out_last
);

   feeder_state_t     state_r, state_nxt_s;
   logic [LEN_W-1:0]  len_r, len_nxt_s;
   logic [LEN_W-1:0]  rd_idx_r, rd_idx_nxt_s;
   logic [LEN_W-1:0]  q_idx_r, q_idx_nxt_s;
   logic              q_valid_r, q_valid_nxt_s;
   pair_t             pair_r, pair_nxt_s;
   logic              out_valid_r, out_valid_nxt_s;
   logic              busy_r, done_r;
   logic              rd_en_s;
   logic [ADDR_W-1:0] rd_addr_s;
   logic [DATA_W-1:0] buf_a_s, buf_b_s;
   logic [LEN_W-1:0]  start_len_s;
   logic              load_s, xfer_s;
   logic              wr_a_s, wr_b_s;

   // Writes land only while idle so a running stream always sees a stable buffer.
   assign wr_a_s = wr_en & ~wr_sel & (state_r == IDLE);
   assign wr_b_s = wr_en &  wr_sel & (state_r == IDLE);

   operand_buf u_buf_a (
      .clk     (clk),
      .wr_en   (wr_a_s),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_en   (rd_en_s),
      .rd_addr (rd_addr_s),
      .rd_data (buf_a_s)
   );

   operand_buf u_buf_b (
      .clk     (clk),
      .wr_en   (wr_b_s),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_en   (rd_en_s),
      .rd_addr (rd_addr_s),
      .rd_data (buf_b_s)
   );

   // Next-state logic: the RAM read word (q) is prefetched one pair ahead of the output register.
   always_comb begin
      state_nxt_s     = state_r;
      len_nxt_s       = len_r;
      rd_idx_nxt_s    = rd_idx_r;
      q_idx_nxt_s     = q_idx_r;
      q_valid_nxt_s   = q_valid_r;
      pair_nxt_s      = pair_r;
      out_valid_nxt_s = out_valid_r;
      rd_en_s         = 1'b0;
      rd_addr_s       = rd_idx_r[ADDR_W-1:0];
      start_len_s     = clamp_len(len);
      xfer_s          = out_valid_r & out_ready;
      load_s          = 1'b0;

      case (state_r)
         IDLE: begin
            if (start) begin
               len_nxt_s = start_len_s;
               if (start_len_s == {LEN_W{1'b0}}) begin
                  state_nxt_s = FIN;
               end else begin
                  state_nxt_s   = STREAM;
                  rd_en_s       = 1'b1;
                  rd_addr_s     = {ADDR_W{1'b0}};
                  rd_idx_nxt_s  = LEN_W'(1);
                  q_idx_nxt_s   = {LEN_W{1'b0}};
                  q_valid_nxt_s = 1'b1;
               end
            end else begin
               state_nxt_s = IDLE;
            end
         end

         STREAM: begin
            load_s = q_valid_r & (~out_valid_r | out_ready);
            if (load_s) begin
               pair_nxt_s.a     = buf_a_s;
               pair_nxt_s.b     = buf_b_s;
               pair_nxt_s.first = (q_idx_r == {LEN_W{1'b0}});
               pair_nxt_s.last  = (q_idx_r == (len_r - LEN_W'(1)));
               out_valid_nxt_s  = 1'b1;
               if (rd_idx_r < len_r) begin
                  rd_en_s      = 1'b1;
                  rd_addr_s    = rd_idx_r[ADDR_W-1:0];
                  rd_idx_nxt_s = rd_idx_r + LEN_W'(1);
                  q_idx_nxt_s  = rd_idx_r;
               end else begin
                  q_valid_nxt_s = 1'b0;
               end
            end else if (xfer_s && pair_r.last) begin
               state_nxt_s     = FIN;
               out_valid_nxt_s = 1'b0;
               pair_nxt_s      = '0;
            end else begin
               out_valid_nxt_s = out_valid_r;
            end
         end

         FIN: begin
            state_nxt_s   = IDLE;
            rd_idx_nxt_s  = {LEN_W{1'b0}};
            q_idx_nxt_s   = {LEN_W{1'b0}};
            q_valid_nxt_s = 1'b0;
         end

         default: begin
            state_nxt_s     = IDLE;
            out_valid_nxt_s = 1'b0;
            q_valid_nxt_s   = 1'b0;
         end
      endcase
   end

   // State, counters and registered outputs; buffer contents are outside this reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= IDLE;
         len_r       <= {LEN_W{1'b0}};
         rd_idx_r    <= {LEN_W{1'b0}};
         q_idx_r     <= {LEN_W{1'b0}};
         q_valid_r   <= 1'b0;
         pair_r      <= '0;
         out_valid_r <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         len_r       <= len_nxt_s;
         rd_idx_r    <= rd_idx_nxt_s;
         q_idx_r     <= q_idx_nxt_s;
         q_valid_r   <= q_valid_nxt_s;
         pair_r      <= pair_nxt_s;
         out_valid_r <= out_valid_nxt_s;
         busy_r      <= (state_nxt_s != IDLE);
         done_r      <= (state_nxt_s == FIN);
      end
   end

   assign busy      = busy_r;
   assign done      = done_r;
   assign out_valid = out_valid_r;
   assign out_a     = pair_r.a;
   assign out_b     = pair_r.b;
   assign out_first = pair_r.first;
   assign out_last  = pair_r.last;

endmodule

// File: tb/tb_mac_operand_feeder.sv
// Directed and randomized bench for mac_operand_feeder against a queue-based pair model.
module tb_mac_operand_feeder;
   import mac_pkg::*;

   logic              clk = 1'b0;
   logic              rst;
   logic              wr_en;
   logic              wr_sel;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              start;
   logic [ADDR_W:0]   len;
   logic              busy, done, out_valid, out_ready;
   logic [DATA_W-1:0] out_a, out_b;
   logic              out_first, out_last;

   always #5 clk = ~clk;

   mac_operand_feeder dut (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (wr_en),
      .wr_sel    (wr_sel),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .start     (start),
      .len       (len),
      .busy      (busy),
      .done      (done),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_a     (out_a),
      .out_b     (out_b),
      .out_first (out_first),
      .out_last  (out_last)
   );

   typedef struct packed {
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
      logic              f;
      logic              l;
   } exp_t;

   int                checks   = 0;
   int                failures = 0;
   logic [DATA_W-1:0] mdl_a [DEPTH];
   logic [DATA_W-1:0] mdl_b [DEPTH];
   exp_t              expq [$];
   longint            mac_sum;
   int                xfers;
   logic [DATA_W-1:0] last_a, last_b;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic buf_write(input bit sel, input int addr, input logic [DATA_W-1:0] data);
      @(negedge clk);
      wr_en   = 1'b1;
      wr_sel  = sel;
      wr_addr = addr[ADDR_W-1:0];
      wr_data = data;
      @(negedge clk);
      wr_en = 1'b0;
      if (sel) mdl_b[addr] = data;
      else     mdl_a[addr] = data;
   endtask

   // rmode: 0 = always ready, 1 = ready pattern 1,0,0,..., 2 = random ready
   task automatic run(input string tag, input int len_in, input int rmode,
                      input bit poke, input int abort_after);
      int   n, last_x;
      bit   stall, fin;
      exp_t held, e, cur;
      n = (len_in > DEPTH) ? DEPTH : len_in;
      expq.delete();
      for (int i = 0; i < n; i++)
         expq.push_back({mdl_a[i], mdl_b[i], (i == 0), (i == n - 1)});
      mac_sum = 0; xfers = 0; last_x = -10; stall = 1'b0; fin = 1'b0; held = '0;
      @(negedge clk);
      start     = 1'b1;
      len       = len_in[ADDR_W:0];
      out_ready = 1'b0;
      @(negedge clk);
      for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
         if (cyc > 0) @(negedge clk);
         start = 1'b0;
         wr_en = 1'b0;
         if (poke && cyc == 2) begin
            start = 1'b1; len = 5'd3;
            wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 4'd0; wr_data = 10'd999;
         end
         cur = {out_a, out_b, out_first, out_last};
         if (cyc == 0) begin
            chk({tag, " busy_after_start"}, busy, 1);
            if (n > 0) chk({tag, " valid_latency_0"}, out_valid, 0);
         end
         if (n > 0 && cyc == 1) chk({tag, " valid_latency_1"}, out_valid, 1);
         if (stall) begin
            chk({tag, " stall_valid"}, out_valid, 1);
            chk({tag, " stall_hold"}, cur, held);
         end
         if (abort_after > 0 && xfers == abort_after) begin
            rst = 1'b1; out_ready = 1'b0;
            @(negedge clk);
            rst = 1'b0;
            chk({tag, " abort_valid"}, out_valid, 0);
            chk({tag, " abort_busy"}, busy, 0);
            chk({tag, " abort_done"}, done, 0);
            @(negedge clk);
            chk({tag, " abort_no_done"}, done, 0);
            fin = 1'b1;
         end else if (done) begin
            chk({tag, " done_timing"}, cyc, (n > 0) ? last_x + 1 : 0);
            chk({tag, " done_all_pairs"}, expq.size(), 0);
            chk({tag, " done_no_valid"}, out_valid, 0);
            @(negedge clk);
            chk({tag, " done_one_cycle"}, done, 0);
            chk({tag, " idle_not_busy"}, busy, 0);
            fin = 1'b1;
         end else begin
            case (rmode)
               0:       out_ready = 1'b1;
               1:       out_ready = (cyc % 3 == 1);
               default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (out_valid) begin
               if (expq.size() == 0) begin
                  chk({tag, " unexpected_valid"}, 1, 0);
               end else if (out_ready) begin
                  e = expq.pop_front();
                  chk({tag, " pair"}, cur, e);
                  mac_sum += longint'(out_a) * longint'(out_b);
                  last_a = out_a; last_b = out_b;
                  last_x = cyc;
                  xfers++;
               end
            end
            stall = out_valid && !out_ready;
            held  = cur;
         end
      end
      if (!fin) chk({tag, " timeout"}, 0, 1);
      out_ready = 1'b0;
      start     = 1'b0;
      wr_en     = 1'b0;
   endtask

   initial begin
      rst = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0;
      start = 1'b0; len = '0; out_ready = 1'b0;
      @(negedge clk); @(negedge clk);
      chk("reset busy", busy, 0);
      chk("reset done", done, 0);
      chk("reset valid", out_valid, 0);
      chk("reset first", out_first, 0);
      chk("reset last", out_last, 0);
      chk("reset a", out_a, 0);
      chk("reset b", out_b, 0);
      rst = 1'b0;

      // A={1..4}, B={10,20,30,40}, remainder random
      for (int i = 0; i < DEPTH; i++) begin
         buf_write(1'b0, i, (i < 4) ? DATA_W'(i + 1) : DATA_W'($urandom));
         buf_write(1'b1, i, (i < 4) ? DATA_W'(10 * (i + 1)) : DATA_W'($urandom));
      end
      run("basic", 4, 0, 1'b0, 0);
      chk("basic mac_sum", 32'(mac_sum), 300);
      chk("basic xfers", xfers, 4);
      run("backpressure", 4, 1, 1'b0, 0);
      chk("backpressure xfers", xfers, 4);
      run("len0", 0, 0, 1'b0, 0);
      run("len1", 1, 1, 1'b0, 0);
      chk("len1 a", last_a, 1);
      chk("len1 b", last_b, 10);

      // A[i]=i, B[i]=1023-i, requested length above depth
      for (int i = 0; i < DEPTH; i++) begin
         buf_write(1'b0, i, DATA_W'(i));
         buf_write(1'b1, i, DATA_W'(1023 - i));
      end
      run("clamp", 20, 2, 1'b0, 0);
      chk("clamp xfers", xfers, 16);
      chk("clamp last_a", last_a, 15);
      chk("clamp last_b", last_b, 1008);

      run("poke", 8, 0, 1'b1, 0);
      chk("poke xfers", xfers, 8);
      run("poke_after", 1, 0, 1'b0, 0);
      chk("poke A0 kept", last_a, 0);

      run("abort", 16, 0, 1'b0, 3);
      run("after_abort", 5, 2, 1'b0, 0);
      chk("after_abort xfers", xfers, 5);

      for (int k = 0; k < 4; k++) begin
         for (int j = 0; j < 6; j++)
            buf_write(1'($urandom_range(0, 1)), $urandom_range(0, DEPTH - 1), DATA_W'($urandom));
         run("random", $urandom_range(0, 20), 2, 1'b0, 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
